// File: rtl/flasher_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the bound_flasher sharing arbiter.
package flasher_pkg;

  localparam int LED_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FLICK      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_RUN        = 3'd3,
    ST_DONE       = 3'd4
  } arb_state_t;

  // Index of the set bit in a one-hot vector of up to 8 requesters.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/flasher_arbiter_rr.sv
`timescale 1ns/1ps
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   first;
  logic [2*N-1:0] oh_dbl;
  logic           found;

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    dbl    = {req, req};
    rot    = N'(dbl >> ptr);
    first  = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        first[k] = 1'b1;
        found    = 1'b1;
      end
    end
    oh_dbl = {{N{1'b0}}, first} << ptr;
    gnt    = oh_dbl[N-1:0] | oh_dbl[2*N-1:N];
    valid  = found;
  end

endmodule

// File: rtl/flasher_arbiter.sv
`timescale 1ns/1ps
// Shares one bound_flasher between N_REQ requesters: round-robin grant,
// registered flick pulse, LED-bus completion detection and timeouts.
module flasher_arbiter
  import flasher_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int FLICK_W   = 2,
  parameter int QUIET_CYC = 4,
  parameter int START_TO  = 8,
  parameter int RUN_TO    = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [15:0]      led,
  output logic             flick,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             err,
  output logic             busy
);

  localparam int PTR_W  = $clog2(N_REQ);
  localparam int CNT_W  = $clog2(RUN_TO + 1);
  localparam int ZCNT_W = $clog2(QUIET_CYC + 1);

  arb_state_t         state_q, state_d;
  logic               flick_q, flick_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ZCNT_W-1:0]  zcnt_q, zcnt_d;

  logic [N_REQ-1:0]   win_gnt;
  logic               win_valid;
  logic [CNT_W-1:0]   cnt_inc;
  logic [ZCNT_W-1:0]  zcnt_inc;
  logic [7:0]         gnt_ext;
  logic [2:0]         win_idx;
  logic [3:0]         win_nxt;
  logic [PTR_W-1:0]   ptr_next;
  logic               led_zero;

  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (win_gnt),
    .valid (win_valid)
  );

  always_comb begin
    led_zero = (led[LED_W-1:0] == '0);
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    zcnt_inc = (zcnt_q == '1) ? zcnt_q : zcnt_q + 1'b1;
    gnt_ext  = '0;
    gnt_ext[N_REQ-1:0] = gnt_q;
    win_idx  = onehot_to_idx(gnt_ext);
    win_nxt  = {1'b0, win_idx} + 4'd1;
    ptr_next = (win_nxt == 4'(N_REQ)) ? '0 : PTR_W'(win_nxt);
  end

  always_comb begin
    state_d = state_q;
    flick_d = flick_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    zcnt_d  = zcnt_q;

    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          gnt_d   = win_gnt;
          flick_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_FLICK;
        end
      end
      ST_FLICK: begin
        if (cnt_q >= CNT_W'(FLICK_W - 1)) begin
          flick_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_WAIT_START;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT_START: begin
        if (!led_zero) begin
          cnt_d   = '0;
          zcnt_d  = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CNT_W'(START_TO)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        cnt_d  = cnt_inc;
        zcnt_d = led_zero ? zcnt_inc : '0;
        // Only a full quiet window ends the run; the flasher's single
        // mid-cycle zero resets on the next nonzero sample.
        if (led_zero && zcnt_inc >= ZCNT_W'(QUIET_CYC)) begin
          done_d  = gnt_q;
          state_d = ST_DONE;
        end else if (cnt_inc >= CNT_W'(RUN_TO)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        gnt_d   = '0;
        ptr_d   = ptr_next;
        cnt_d   = '0;
        zcnt_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        flick_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      flick_q <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      zcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      flick_q <= flick_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      zcnt_q  <= zcnt_d;
    end
  end

  assign flick = flick_q;
  assign gnt   = gnt_q;
  assign done  = done_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_flasher_arbiter.sv
`timescale 1ns/1ps
// Directed bench for flasher_arbiter; LED activity is driven cycle by cycle.
module tb_flasher_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] led;
  logic        flick;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        err;
  logic        busy;

  int n_cmp;
  int n_mis;

  flasher_arbiter #(
    .N_REQ     (4),
    .FLICK_W   (2),
    .QUIET_CYC (4),
    .START_TO  (8),
    .RUN_TO    (512)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .led   (led),
    .flick (flick),
    .gnt   (gnt),
    .done  (done),
    .err   (err),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Four zero LED samples end the run; done pulses for one cycle, then idle.
  task automatic quiet_end(input logic [3:0] g, input string tag);
    led = 16'h0000;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_done_early"}, 32'(done), 32'h0);
      chk({tag, "_no_flick"}, 32'(flick), 32'h0);
    end
    tick();
    chk({tag, "_done"}, 32'(done), 32'(g));
    chk({tag, "_err_clear"}, 32'(err), 32'h0);
    chk({tag, "_busy_done"}, 32'(busy), 32'h1);
    tick();
    chk({tag, "_done_one"}, 32'(done), 32'h0);
    chk({tag, "_gnt_clr"}, 32'(gnt), 32'h0);
    chk({tag, "_busy_low"}, 32'(busy), 32'h0);
  endtask

  task automatic do_cycle(input logic [3:0] g, input bit drop, input string tag);
    tick();
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_flick1"}, 32'(flick), 32'h1);
    chk({tag, "_busy"}, 32'(busy), 32'h1);
    if (drop) req = '0;
    tick();
    chk({tag, "_flick2"}, 32'(flick), 32'h1);
    tick();
    chk({tag, "_flick_off"}, 32'(flick), 32'h0);
    chk({tag, "_gnt_hold"}, 32'(gnt), 32'(g));
    led = 16'h0001;
    tick();
    led = 16'h0003;
    tick();
    led = 16'h0007;
    tick();
    quiet_end(g, tag);
  endtask

  initial begin
    logic seen_err;
    logic seen_done;
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    req   = '0;
    led   = '0;

    tick();
    tick();
    chk("rst_flick", 32'(flick), 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_noreq", 32'(busy), 32'h0);

    // Single requester through a full flash cycle.
    req = 4'b0001;
    do_cycle(4'b0001, 1'b0, "t1");

    // Reset while flick is high: flick must drop without waiting for a clock.
    req = 4'b1111;
    tick();
    chk("rstf_gnt", 32'(gnt), 32'h2);
    chk("rstf_flick", 32'(flick), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstf_flick0", 32'(flick), 32'h0);
    chk("rstf_gnt0", 32'(gnt), 32'h0);
    chk("rstf_busy0", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // All four held: rotation 0,1,2,3,0.
    do_cycle(4'b0001, 1'b0, "t2a");
    do_cycle(4'b0010, 1'b0, "t2b");
    do_cycle(4'b0100, 1'b0, "t2c");
    do_cycle(4'b1000, 1'b0, "t2d");
    do_cycle(4'b0001, 1'b0, "t2e");

    // Start timeout: LEDs never light after the flick.
    tick();
    chk("t3_gnt", 32'(gnt), 32'h2);
    tick();
    tick();
    chk("t3_flick_off", 32'(flick), 32'h0);
    seen_err = 1'b0;
    for (int unsigned i = 0; i < 7; i++) begin
      tick();
      seen_err |= err;
    end
    chk("t3_err_early", 32'(seen_err), 32'h0);
    tick();
    chk("t3_err", 32'(err), 32'h1);
    chk("t3_no_done", 32'(done), 32'h0);
    chk("t3_busy", 32'(busy), 32'h1);
    tick();
    chk("t3_err_one", 32'(err), 32'h0);
    chk("t3_idle", 32'(busy), 32'h0);
    chk("t3_done_after", 32'(done), 32'h0);
    do_cycle(4'b0100, 1'b0, "t3n");

    // Quiet gap shorter than the window must not finish the run.
    tick();
    chk("t4_gnt", 32'(gnt), 32'h8);
    tick();
    tick();
    chk("t4_flick_off", 32'(flick), 32'h0);
    led = 16'h0180;
    tick();
    led = 16'h03C0;
    tick();
    led = 16'h0000;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk("t4_gap_done", 32'(done), 32'h0);
    end
    led = 16'h0001;
    tick();
    chk("t4_gap_nodone", 32'(done), 32'h0);
    chk("t4_gap_busy", 32'(busy), 32'h1);
    quiet_end(4'b1000, "t4");

    // Requester drops req mid-run: still completes with done.
    req = 4'b0100;
    do_cycle(4'b0100, 1'b1, "t6a");

    // Reset during RUN forgets the run and clears the pointer.
    req = 4'b0010;
    tick();
    chk("t5_gnt", 32'(gnt), 32'h2);
    tick();
    tick();
    led = 16'h0001;
    tick();
    tick();
    chk("t5_run_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_gnt0", 32'(gnt), 32'h0);
    chk("t5_busy0", 32'(busy), 32'h0);
    chk("t5_flick0", 32'(flick), 32'h0);
    #50;
    req = 4'b1010;
    chk("t5_in_rst_gnt", 32'(gnt), 32'h0);
    chk("t5_in_rst_done", 32'(done), 32'h0);
    chk("t5_in_rst_err", 32'(err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    led = 16'h0000;
    tick();
    chk("t5_regnt", 32'(gnt), 32'h2);
    chk("t5_no_done", 32'(done), 32'h0);
    chk("t5_no_err", 32'(err), 32'h0);

    // Same grant: LEDs stuck on, run timeout after 512 RUN cycles.
    tick();
    tick();
    chk("t6b_flick_off", 32'(flick), 32'h0);
    led = 16'h8001;
    tick();
    seen_err  = 1'b0;
    seen_done = 1'b0;
    for (int unsigned i = 0; i < 511; i++) begin
      tick();
      seen_err  |= err;
      seen_done |= (done != 4'b0000);
    end
    chk("t6b_err_early", 32'(seen_err), 32'h0);
    chk("t6b_done_early", 32'(seen_done), 32'h0);
    tick();
    chk("t6b_err", 32'(err), 32'h1);
    chk("t6b_no_done", 32'(done), 32'h0);
    tick();
    chk("t6b_idle", 32'(busy), 32'h0);
    chk("t6b_gnt0", 32'(gnt), 32'h0);
    req = 4'b0000;
    led = 16'h0000;
    tick();
    chk("end_idle", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
